if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the 32-bit pipelined RISC-V core. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. It honours stall requests from the hazard unit and redirects from branch/JAL resolution in EX. It halts with a sticky error on a misaligned redirect target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0) placed in IF/ID on flush/halt.
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents (load-use hazard).
- redirect_valid  in  1  taken branch / JAL resolved in EX; flush and jump.
- redirect_pc  in  32  target byte address of redirect.
- imem_addr  out  32  byte address presented to instruction memory (= current PC).
- imem_instr  in  32  instruction returned combinationally for imem_addr.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  fetched instruction (NOP_INSTR when not valid).
- ifid_pc  out  32  byte address of ifid_instr.
- ifid_pc4  out  32  ifid_pc + 4 (JAL link value).
- fetch_err  out  1  sticky: misaligned redirect seen, fetch halted.
- err_pc  out  32  offending redirect_pc, captured with fetch_err.
- fetch_count  out  32  number of instructions written valid into IF/ID.

## Operation
- FSM states: RUN, HALT. Reset enters RUN.
- Per-edge priority in RUN: rst > redirect_valid > stall > normal advance.
- Normal: IF/ID <= {valid=1, imem_instr, pc, pc+4}; pc <= pc+4; fetch_count += 1.
- stall (no redirect): pc, IF/ID, fetch_count unchanged.
- redirect_valid, aligned target (redirect_pc[1:0]==0): pc <= redirect_pc; IF/ID <= bubble (valid=0, NOP_INSTR, pc/pc4 fields 0); overrides stall.
- redirect_valid, misaligned target: go to HALT; fetch_err <= 1; err_pc <= redirect_pc; IF/ID <= bubble; pc unchanged.
- HALT: pc frozen, IF/ID held as bubble, all inputs except rst ignored; exit only via rst.
- Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000, no flag). fetch_count wraps modulo 2^32.
- imem_instr of 0x0000_0000 (unmapped memory) is captured as-is with valid=1; decode handles it.

## Timing
- Reset values: pc=RESET_PC (so imem_addr=RESET_PC), ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0, fetch_err=0, err_pc=0, fetch_count=0, state=RUN.
- imem_addr is a direct register output and is stable for the whole cycle. The memory is combinational, so fetch latency is 1 cycle from PC to IF/ID.
- First valid IF/ID entry appears on the first edge after rst deasserts.
- Redirect penalty: the edge with redirect_valid writes a bubble. The target instruction is valid in IF/ID one edge later.
- rst asserted mid-operation, including in HALT: the next edge restores all reset values regardless of other inputs.
- Simultaneous stall and redirect_valid: redirect wins.

## Structure
- Shared package `rv_pkg`: XLEN=32, NOP_INSTR constant, fetch FSM state enum, and an IF/ID payload struct (valid, instr, pc, pc4) reused by the decode stage.
- Single module; no sub-module needed. The PC register, IF/ID register, and counter are all inline.

## Test plan
- Reset then 5 free-running cycles with the standard program loaded: IF/ID shows pc 0,4,8,12,16 with instr 0x00500113, 0x00C00193, 0xFF718393, 0x0023E233, 0x0041F2B3; fetch_count=5.
- stall held 3 cycles at pc=8: imem_addr stays 8, IF/ID holds pc 4 / 0x00C00193, fetch_count unchanged. Release: next IF/ID has pc 8.
- redirect_valid with redirect_pc=0x40 asserted together with stall: next edge gives ifid_valid=0 and ifid_instr=0x00000013. The edge after gives pc 0x40, instr 0x00210063, pc4 0x44.
- redirect_pc=0x42: fetch_err=1, err_pc=0x42, ifid_valid stays 0 for 10 cycles, imem_addr frozen. rst then returns imem_addr=0 and fetch_err=0.
- RESET_PC=0xFFFF_FFFC: after one advance, ifid_pc=0xFFFF_FFFC, ifid_pc4=0x0, and imem_addr=0x0.
- rst asserted during a redirect cycle: all outputs return to reset values and the redirect is ignored.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared core package: datapath width, bubble encoding, fetch FSM states
// and the IF/ID payload consumed by decode.
package rv_pkg;

  localparam int XLEN = 32;

  // ADDI x0,x0,0 - canonical bubble placed in IF/ID
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc4: '0};

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC register, combinational imem address, IF/ID capture,
// stall/redirect handling and a sticky halt on misaligned redirect targets.
module if_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc4,
  output logic            fetch_err,
  output logic [XLEN-1:0] err_pc,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  ifid_t           ifid_q, ifid_nxt;
  logic            err_q, err_nxt;
  logic [XLEN-1:0] errpc_q, errpc_nxt;
  logic [XLEN-1:0] cnt_q, cnt_nxt;
  logic [XLEN-1:0] pc_plus4;

  // pc+4 wraps modulo 2^32 with no overflow indication
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state: redirect beats stall beats advance; HALT only leaves on rst
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ifid_nxt  = ifid_q;
    err_nxt   = err_q;
    errpc_nxt = errpc_q;
    cnt_nxt   = cnt_q;
    case (state)
      FETCH_RUN: begin
        if (redirect_valid) begin
          ifid_nxt = IFID_BUBBLE;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_nxt = redirect_pc;
          end else begin
            // PC stays put so err_pc/imem_addr show where fetch stopped
            state_nxt = FETCH_HALT;
            err_nxt   = 1'b1;
            errpc_nxt = redirect_pc;
          end
        end else if (!stall) begin
          ifid_nxt = '{valid: 1'b1, instr: imem_instr, pc: pc_q, pc4: pc_plus4};
          pc_nxt   = pc_plus4;
          cnt_nxt  = cnt_q + 32'd1;
        end
      end
      FETCH_HALT: ifid_nxt = IFID_BUBBLE;
      default:    state_nxt = FETCH_RUN;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH_RUN;
      pc_q    <= RESET_PC;
      ifid_q  <= IFID_BUBBLE;
      err_q   <= 1'b0;
      errpc_q <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      ifid_q  <= ifid_nxt;
      err_q   <= err_nxt;
      errpc_q <= errpc_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_valid  = ifid_q.valid;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_pc4    = ifid_q.pc4;
  assign fetch_err   = err_q;
  assign err_pc      = errpc_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: expected IF/ID entries are queued as
// stimulus is driven and popped once the edge has produced them.
module tb_if_fetch_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst_w, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr, ifid_instr, ifid_pc, ifid_pc4, err_pc, fetch_count;
  logic        ifid_valid, fetch_err;
  logic [31:0] w_addr, w_instr, w_ifid_instr, w_ifid_pc, w_ifid_pc4, w_err_pc, w_count;
  logic        w_valid, w_err;

  int vectors = 0;
  int miscompares = 0;
  ifid_t exp_q[$];

  always #5 clk = ~clk;

  // Program image; low unmapped words get a recognisable filler, high memory reads 0
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h00: mem = 32'h0050_0113;
      32'h04: mem = 32'h00C0_0193;
      32'h08: mem = 32'hFF71_8393;
      32'h0C: mem = 32'h0023_E233;
      32'h10: mem = 32'h0041_F2B3;
      32'h40: mem = 32'h0021_0063;
      default: mem = (a < 32'h100) ? {16'hC0DE, a[15:0]} : 32'h0;
    endcase
  endfunction

  assign imem_instr = mem(imem_addr);
  assign w_instr    = mem(w_addr);

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4), .fetch_err(fetch_err), .err_pc(err_pc),
    .fetch_count(fetch_count)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem_addr(w_addr), .imem_instr(w_instr),
    .ifid_valid(w_valid), .ifid_instr(w_ifid_instr), .ifid_pc(w_ifid_pc),
    .ifid_pc4(w_ifid_pc4), .fetch_err(w_err), .err_pc(w_err_pc),
    .fetch_count(w_count)
  );

  function automatic ifid_t ent(input logic [31:0] pc);
    ent = '{valid: 1'b1, instr: mem(pc), pc: pc, pc4: pc + 32'd4};
  endfunction

  function automatic ifid_t got_main();
    got_main = '{valid: ifid_valid, instr: ifid_instr, pc: ifid_pc, pc4: ifid_pc4};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifid_t e, g;
    rst = 1'b1; rst_w = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    exp_q.push_back(IFID_BUBBLE);
    step(); step();
    e = exp_q.pop_front(); g = got_main();
    vectors++;
    if (g !== e) begin miscompares++; $display("FAIL reset_ifid got=%h exp=%h", g, e); end
    vectors++;
    if ({imem_addr, fetch_err, err_pc, fetch_count} !== {32'h0, 1'b0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_regs got addr=%h err=%b errpc=%h cnt=%h exp 0/0/0/0",
               imem_addr, fetch_err, err_pc, fetch_count);
    end
  endtask

  task automatic test_run();
    ifid_t e, g;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ent(32'(i * 4)));
      step();
      e = exp_q.pop_front(); g = got_main();
      vectors++;
      if (g !== e) begin miscompares++; $display("FAIL run%0d got=%h exp=%h", i, g, e); end
    end
    vectors++;
    if (fetch_count !== 32'd5 || imem_addr !== 32'h14) begin
      miscompares++;
      $display("FAIL run_count got cnt=%0d addr=%h exp 5/00000014", fetch_count, imem_addr);
    end
  endtask

  task automatic test_stall();
    ifid_t e, g;
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();                      // IF/ID pc 4, PC 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ent(32'h4));
      step();
      e = exp_q.pop_front(); g = got_main();
      vectors++;
      if (g !== e || imem_addr !== 32'h8 || fetch_count !== 32'd2) begin
        miscompares++;
        $display("FAIL stall%0d got=%h addr=%h cnt=%0d exp=%h addr=8 cnt=2", i, g, imem_addr, fetch_count, e);
      end
    end
    stall = 1'b0;
    exp_q.push_back(ent(32'h8));
    step();
    e = exp_q.pop_front(); g = got_main();
    vectors++;
    if (g !== e || fetch_count !== 32'd3) begin
      miscompares++;
      $display("FAIL stall_release got=%h cnt=%0d exp=%h cnt=3", g, fetch_count, e);
    end
  endtask

  task automatic test_redirect();
    ifid_t e, g;
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    exp_q.push_back(IFID_BUBBLE);
    step();
    e = exp_q.pop_front(); g = got_main();
    vectors++;
    if (g !== e || imem_addr !== 32'h40 || fetch_count !== 32'd3) begin
      miscompares++;
      $display("FAIL redirect_bubble got=%h addr=%h cnt=%0d exp=%h addr=40 cnt=3", g, imem_addr, fetch_count, e);
    end
    stall = 1'b0; redirect_valid = 1'b0;
    exp_q.push_back('{valid: 1'b1, instr: 32'h0021_0063, pc: 32'h40, pc4: 32'h44});
    step();
    e = exp_q.pop_front(); g = got_main();
    vectors++;
    if (g !== e || fetch_count !== 32'd4) begin
      miscompares++;
      $display("FAIL redirect_target got=%h cnt=%0d exp=%h cnt=4", g, fetch_count, e);
    end
  endtask

  task automatic test_back_to_back();
    ifid_t e, g;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    exp_q.push_back(IFID_BUBBLE);
    step();
    redirect_pc = 32'h40;
    exp_q.push_back(IFID_BUBBLE);
    step();
    redirect_valid = 1'b0;
    exp_q.push_back(ent(32'h40));
    step();
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      vectors++;
      // only the last entry is still visible; earlier two are checked via count
      if (i == 2) begin
        g = got_main();
        if (g !== e || fetch_count !== 32'd5) begin
          miscompares++;
          $display("FAIL b2b_redirect got=%h cnt=%0d exp=%h cnt=5", g, fetch_count, e);
        end
      end else if (e.valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_queue entry%0d valid=%b exp 0", i, e.valid);
      end
    end
  endtask

  task automatic test_misaligned();
    ifid_t e, g;
    // PC is 0x44 here
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    exp_q.push_back(IFID_BUBBLE);
    step();
    e = exp_q.pop_front(); g = got_main();
    vectors++;
    if (g !== e || fetch_err !== 1'b1 || err_pc !== 32'h42 || imem_addr !== 32'h44) begin
      miscompares++;
      $display("FAIL misalign got=%h err=%b errpc=%h addr=%h exp=%h err=1 errpc=42 addr=44",
               g, fetch_err, err_pc, imem_addr, e);
    end
    for (int i = 0; i < 10; i++) begin
      redirect_valid = i[0]; redirect_pc = 32'h80 + 32'(i * 4); stall = i[1];
      exp_q.push_back(IFID_BUBBLE);
      step();
      e = exp_q.pop_front(); g = got_main();
      vectors++;
      if (g !== e || fetch_err !== 1'b1 || err_pc !== 32'h42 || imem_addr !== 32'h44 || fetch_count !== 32'd5) begin
        miscompares++;
        $display("FAIL halt%0d got=%h err=%b errpc=%h addr=%h cnt=%0d", i, g, fetch_err, err_pc, imem_addr, fetch_count);
      end
    end
    rst = 1'b1; redirect_valid = 1'b0; stall = 1'b0;
    step();
    vectors++;
    if ({imem_addr, fetch_err, err_pc, fetch_count} !== {32'h0, 1'b0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL halt_reset got addr=%h err=%b errpc=%h cnt=%h exp 0/0/0/0",
               imem_addr, fetch_err, err_pc, fetch_count);
    end
    rst = 1'b0;
    exp_q.push_back(ent(32'h0));
    step();
    e = exp_q.pop_front(); g = got_main();
    vectors++;
    if (g !== e) begin miscompares++; $display("FAIL halt_resume got=%h exp=%h", g, e); end
  endtask

  task automatic test_wrap();
    ifid_t e, g;
    vectors++;
    if (w_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_reset_addr got=%h exp=fffffffc", w_addr);
    end
    rst_w = 1'b0;
    // high memory reads 0: unmapped word still captured valid
    exp_q.push_back('{valid: 1'b1, instr: 32'h0, pc: 32'hFFFF_FFFC, pc4: 32'h0});
    step();
    e = exp_q.pop_front();
    g = '{valid: w_valid, instr: w_ifid_instr, pc: w_ifid_pc, pc4: w_ifid_pc4};
    vectors++;
    if (g !== e || w_addr !== 32'h0 || w_count !== 32'd1) begin
      miscompares++;
      $display("FAIL wrap got=%h addr=%h cnt=%0d exp=%h addr=0 cnt=1", g, w_addr, w_count, e);
    end
  endtask

  task automatic test_rst_redirect();
    ifid_t e, g;
    step(); step();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    exp_q.push_back(IFID_BUBBLE);
    step();
    e = exp_q.pop_front(); g = got_main();
    vectors++;
    if (g !== e || imem_addr !== 32'h0 || fetch_count !== 32'd0 || fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_redirect got=%h addr=%h cnt=%0d err=%b exp=%h addr=0", g, imem_addr, fetch_count, fetch_err, e);
    end
    rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    exp_q.push_back(ent(32'h0));
    step();
    e = exp_q.pop_front(); g = got_main();
    vectors++;
    if (g !== e || fetch_count !== 32'd1) begin
      miscompares++;
      $display("FAIL rst_redirect_resume got=%h cnt=%0d exp=%h cnt=1", g, fetch_count, e);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_rst_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
